path_metric_unit: RTL and testbench

//  Add-compare-select (ACS) and path-metric storage stage of the K=4, rate-1/2 Viterbi decoder.

---
 rtl/vd_pkg.sv | 14 +
 rtl/acs_unit.sv | 30 +++
 rtl/path_metric_unit.sv | 101 ++++++++++
 tb/tb_path_metric_unit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/vd_pkg.sv
// Shared types and trellis helpers for the K=4, rate-1/2 Viterbi decoder.
package vd_pkg;
    localparam int NUM_STATES = 8;
    localparam int STATE_W    = 3;
    localparam int BM_W       = 2;

    typedef logic [1:0][BM_W-1:0]          bm_pair_t;
    typedef bm_pair_t [NUM_STATES-1:0]     bm_bus_t;

    // Predecessor k (0 or 1) of next state ns in the shift-register trellis.
    function automatic logic [STATE_W-1:0] pred(input logic [STATE_W-1:0] ns, input logic k);
        return {k, ns[2:1]};
    endfunction
endpackage

// File: rtl/acs_unit.sv
// Combinational add-compare-select for one trellis state; saturating add, ties pick predecessor 0.
module acs_unit
    import vd_pkg::*;
#(
    parameter int PM_W = 5
) (
    input  logic [PM_W-1:0] pm0,
    input  logic [PM_W-1:0] pm1,
    input  logic [BM_W-1:0] bm0,
    input  logic [BM_W-1:0] bm1,
    output logic [PM_W-1:0] pm_sel,
    output logic            dec
);
    localparam logic [PM_W:0] SAT_VAL = {1'b0, {PM_W{1'b1}}};

    logic [PM_W:0] sum0;
    logic [PM_W:0] sum1;
    logic [PM_W:0] c0;
    logic [PM_W:0] c1;

    assign sum0 = {1'b0, pm0} + {{(PM_W + 1 - BM_W){1'b0}}, bm0};
    assign sum1 = {1'b0, pm1} + {{(PM_W + 1 - BM_W){1'b0}}, bm1};

    // Clamp at the largest storable metric so the compare never sees a wrapped value.
    assign c0 = sum0[PM_W] ? SAT_VAL : sum0;
    assign c1 = sum1[PM_W] ? SAT_VAL : sum1;

    assign dec    = (c1 < c0);
    assign pm_sel = dec ? c1[PM_W-1:0] : c0[PM_W-1:0];
endmodule

// File: rtl/path_metric_unit.sv
// Viterbi ACS stage: 8 path-metric registers, normalization, argmin and registered
// survivor decisions for the traceback memory.
module path_metric_unit
    import vd_pkg::*;
#(
    parameter int PM_W    = 5,
    parameter int INIT_PM = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  init,
    input  logic                  valid_in,
    input  bm_bus_t               bm_in,
    output logic                  valid_out,
    output logic [NUM_STATES-1:0] dec_out,
    output logic [STATE_W-1:0]    best_state,
    output logic [PM_W-1:0]       best_pm
);
    localparam logic [PM_W-1:0] INIT_PM_V = PM_W'(INIT_PM);

    logic [PM_W-1:0]       pm_reg  [NUM_STATES];
    logic [PM_W-1:0]       sel_pm  [NUM_STATES];
    logic [PM_W-1:0]       pm_next [NUM_STATES];
    logic [NUM_STATES-1:0] dec_next;
    logic [NUM_STATES-1:0] msb_set;
    logic                  norm_en;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_STATES; gi++) begin : g_acs
            localparam logic [STATE_W-1:0] NS = STATE_W'(gi);
            localparam logic [STATE_W-1:0] P0 = pred(NS, 1'b0);
            localparam logic [STATE_W-1:0] P1 = pred(NS, 1'b1);

            acs_unit #(.PM_W(PM_W)) u_acs (
                .pm0    (pm_reg[P0]),
                .pm1    (pm_reg[P1]),
                .bm0    (bm_in[P0][NS[0]]),
                .bm1    (bm_in[P1][NS[0]]),
                .pm_sel (sel_pm[gi]),
                .dec    (dec_next[gi])
            );

            assign msb_set[gi] = sel_pm[gi][PM_W-1];
            // Dropping the shared MSB keeps all relative distances intact.
            assign pm_next[gi] = norm_en ? {1'b0, sel_pm[gi][PM_W-2:0]} : sel_pm[gi];
        end
    endgenerate

    assign norm_en = &msb_set;

    // Argmin tree: lower index sits on the left and wins unless the right is strictly smaller.
    logic [STATE_W-1:0] l1_idx [4];
    logic [PM_W-1:0]    l1_val [4];
    logic [STATE_W-1:0] l2_idx [2];
    logic [PM_W-1:0]    l2_val [2];
    logic [STATE_W-1:0] best_idx_next;
    logic [PM_W-1:0]    best_val_next;

    generate
        for (gi = 0; gi < 4; gi++) begin : g_min_l1
            assign l1_idx[gi] = (pm_next[2*gi+1] < pm_next[2*gi]) ? STATE_W'(2*gi+1) : STATE_W'(2*gi);
            assign l1_val[gi] = (pm_next[2*gi+1] < pm_next[2*gi]) ? pm_next[2*gi+1] : pm_next[2*gi];
        end
        for (gi = 0; gi < 2; gi++) begin : g_min_l2
            assign l2_idx[gi] = (l1_val[2*gi+1] < l1_val[2*gi]) ? l1_idx[2*gi+1] : l1_idx[2*gi];
            assign l2_val[gi] = (l1_val[2*gi+1] < l1_val[2*gi]) ? l1_val[2*gi+1] : l1_val[2*gi];
        end
    endgenerate

    assign best_idx_next = (l2_val[1] < l2_val[0]) ? l2_idx[1] : l2_idx[0];
    assign best_val_next = (l2_val[1] < l2_val[0]) ? l2_val[1] : l2_val[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_STATES; i++) begin
                pm_reg[i] <= (i == 0) ? '0 : INIT_PM_V;
            end
            valid_out  <= 1'b0;
            dec_out    <= '0;
            best_state <= '0;
            best_pm    <= '0;
        end else if (init) begin
            for (int i = 0; i < NUM_STATES; i++) begin
                pm_reg[i] <= (i == 0) ? '0 : INIT_PM_V;
            end
            valid_out  <= 1'b0;
            dec_out    <= '0;
            best_state <= '0;
            best_pm    <= '0;
        end else begin
            valid_out <= valid_in;
            if (valid_in) begin
                pm_reg     <= pm_next;
                dec_out    <= dec_next;
                best_state <= best_idx_next;
                best_pm    <= best_val_next;
            end
        end
    end
endmodule

// File: tb/tb_path_metric_unit.sv
// Bench for path_metric_unit: directed vector table, corner sequences and a
// randomized encoded stream checked against an arithmetic ACS model.
module tb_path_metric_unit;
    import vd_pkg::*;

    localparam int PM_W    = 5;
    localparam int INIT_PM = 8;
    localparam int PM_MAX  = (1 << PM_W) - 1;
    localparam int PM_HALF = 1 << (PM_W - 1);

    logic            clk;
    logic            rst_n;
    logic            init;
    logic            valid_in;
    bm_bus_t         bm_in;
    logic            valid_out;
    logic [7:0]      dec_out;
    logic [2:0]      best_state;
    logic [PM_W-1:0] best_pm;

    path_metric_unit #(.PM_W(PM_W), .INIT_PM(INIT_PM)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .init       (init),
        .valid_in   (valid_in),
        .bm_in      (bm_in),
        .valid_out  (valid_out),
        .dec_out    (dec_out),
        .best_state (best_state),
        .best_pm    (best_pm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Drive one cycle from a negedge; returns at the following negedge with outputs settled.
    task automatic apply(input logic v, input logic in_init, input logic [31:0] bm);
        valid_in = v;
        init     = in_init;
        bm_in    = bm;
        @(negedge clk);
        valid_in = 1'b0;
        init     = 1'b0;
    endtask

    task automatic chk_out(input string name, input int v, input int d, input int bs, input int bpm);
        chk({name, ".valid_out"},  int'(valid_out),  v);
        chk({name, ".dec_out"},    int'(dec_out),    d);
        chk({name, ".best_state"}, int'(best_state), bs);
        chk({name, ".best_pm"},    int'(best_pm),    bpm);
    endtask

    // Reference model: plain integer metrics computed from the trellis rules.
    int m_pm [8];

    function automatic int bm_of(input logic [31:0] bm, input int p, input int b);
        return int'((bm >> (p * 4 + b * 2)) & 32'h3);
    endfunction

    task automatic model_init();
        for (int i = 0; i < 8; i++) m_pm[i] = (i == 0) ? 0 : INIT_PM;
    endtask

    task automatic model_step(input logic [31:0] bm, output int dec, output int bs, output int bpm);
        int np [8];
        bit all_hi;
        dec = 0;
        for (int ns = 0; ns < 8; ns++) begin
            int a, b, c0, c1;
            a  = ns / 2;
            b  = ns % 2;
            c0 = m_pm[a] + bm_of(bm, a, b);
            c1 = m_pm[a + 4] + bm_of(bm, a + 4, b);
            if (c0 > PM_MAX) c0 = PM_MAX;
            if (c1 > PM_MAX) c1 = PM_MAX;
            if (c1 < c0) begin
                np[ns] = c1;
                dec += (1 << ns);
            end else begin
                np[ns] = c0;
            end
        end
        all_hi = 1'b1;
        for (int s = 0; s < 8; s++) if (np[s] < PM_HALF) all_hi = 1'b0;
        if (all_hi) for (int s = 0; s < 8; s++) np[s] -= PM_HALF;
        bs  = 0;
        bpm = np[0];
        for (int s = 0; s < 8; s++) begin
            m_pm[s] = np[s];
            if (np[s] < bpm) begin
                bs  = s;
                bpm = np[s];
            end
        end
    endtask

    typedef struct {
        string       name;
        logic [31:0] bm;
        int          dec;
        int          bs;
        int          bpm;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int exp_norm [9];
        int e_dec, e_bs, e_bpm;
        int last_dec, last_bs, last_bpm;
        int enc;

        // One step from the initial metrics {0,8,8,8,8,8,8,8}; bm[p][b] sits at bit p*4+b*2.
        vecs[0] = '{"all_zero",   32'h0000_0000, 8'h00, 0, 0};
        vecs[1] = '{"all_three",  32'hFFFF_FFFF, 8'h00, 0, 3};
        vecs[2] = '{"p1_wins",    32'h0000_FFF0, 8'hFC, 0, 0};
        vecs[3] = '{"best_is_1",  32'h0000_0007, 8'h00, 1, 1};
        vecs[4] = '{"tie_best",   32'h0000_000A, 8'h00, 0, 2};
        vecs[5] = '{"tie_all",    32'h5555_5555, 8'h00, 0, 1};
        vecs[6] = '{"tie_ns5_c1", 32'h5155_5555, 8'h20, 0, 1};

        exp_norm = '{2, 4, 6, 8, 10, 12, 14, 0, 2};

        rst_n    = 1'b0;
        init     = 1'b0;
        valid_in = 1'b0;
        bm_in    = '0;
        repeat (2) @(negedge clk);
        chk_out("reset", 0, 0, 0, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            apply(1'b0, 1'b1, 32'h0);
            apply(1'b1, 1'b0, vecs[i].bm);
            chk_out(vecs[i].name, 1, vecs[i].dec, vecs[i].bs, vecs[i].bpm);
        end

        // Clean all-zero codeword stream.
        apply(1'b0, 1'b1, 32'h0);
        for (int i = 0; i < 10; i++) begin
            apply(1'b1, 1'b0, 32'h8888_8888);
            chk("clean.valid_out",  int'(valid_out),  1);
            chk("clean.dec0",       int'(dec_out[0]), 0);
            chk("clean.best_state", int'(best_state), 0);
            chk("clean.best_pm",    int'(best_pm),    0);
            apply(1'b0, 1'b0, 32'h8888_8888);
            chk("clean.gap_valid",  int'(valid_out),  0);
        end

        // Worst-case bm=2 everywhere: metrics climb until all MSBs set, then drop by 16.
        apply(1'b0, 1'b1, 32'h0);
        for (int i = 0; i < 9; i++) begin
            apply(1'b1, 1'b0, 32'hAAAA_AAAA);
            chk_out($sformatf("norm%0d", i), 1, 0, 0, exp_norm[i]);
        end

        // Asynchronous reset mid-stream, away from any clock edge.
        rst_n = 1'b0;
        #2;
        chk_out("async_rst", 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        apply(1'b0, 1'b0, 32'h0000_0007);
        chk_out("post_rst_idle", 0, 0, 0, 0);
        apply(1'b1, 1'b0, 32'h0000_0007);
        chk_out("post_rst_sym", 1, 0, 1, 1);
        apply(1'b1, 1'b1, 32'h0);
        apply(1'b1, 1'b0, 32'h0);
        chk_out("spec_rst_zero", 1, 0, 0, 0);

        // Gaps hold outputs; init colliding with valid_in drops the symbol.
        apply(1'b0, 1'b1, 32'h0);
        apply(1'b1, 1'b0, 32'h5155_5555);
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 1'b0, 32'hFFFF_FFFF);
            chk_out($sformatf("gap%0d", i), 0, 8'h20, 0, 1);
        end
        apply(1'b1, 1'b1, 32'h0000_0007);
        chk_out("collide", 0, 0, 0, 0);
        apply(1'b1, 1'b0, 32'h0000_0007);
        chk_out("after_collide", 1, 0, 1, 1);

        // Random encoded stream (G = 1111, 1101) with one channel bit flipped per 8 symbols.
        apply(1'b0, 1'b1, 32'h0);
        model_init();
        enc      = 0;
        last_dec = 0;
        last_bs  = 0;
        last_bpm = 0;
        for (int n = 0; n < 200; n++) begin
            logic [31:0] bm;
            int b, rx;
            if ($urandom_range(9) == 0) begin
                apply(1'b0, 1'b0, $urandom);
                chk_out($sformatf("rnd_gap%0d", n), 0, last_dec, last_bs, last_bpm);
            end
            b  = int'($urandom_range(1));
            rx = ($countones(((enc << 1) | b) & 4'hF) % 2) * 2 + ($countones(((enc << 1) | b) & 4'hD) % 2);
            if (n % 8 == 5) rx = rx ^ (1 << $urandom_range(1));
            enc = ((enc << 1) | b) & 7;
            bm  = '0;
            for (int p = 0; p < 8; p++) begin
                for (int bb = 0; bb < 2; bb++) begin
                    int tx, d;
                    tx = ($countones(((p << 1) | bb) & 4'hF) % 2) * 2 + ($countones(((p << 1) | bb) & 4'hD) % 2);
                    d  = $countones((tx ^ rx) & 3);
                    bm = bm | (32'(d) << (p * 4 + bb * 2));
                end
            end
            apply(1'b1, 1'b0, bm);
            model_step(bm, e_dec, e_bs, e_bpm);
            chk_out($sformatf("rnd%0d", n), 1, e_dec, e_bs, e_bpm);
            last_dec = e_dec;
            last_bs  = e_bs;
            last_bpm = e_bpm;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
